memaccess: RTL
==============

// Module: memaccess
// PURPOSE
// - LC3 memory-access stage. Sits between execute and writeback.
// - Performs LD/LDI/ST/STI data-memory transactions over a ready-handshaked memory port.
// - Presents the loaded word on memout; writeback selects it with W_Control=1.
// - A multi-cycle FSM resolves indirect (pointer) accesses. A watchdog bounds memory waits.
// PARAMETERS
// - TIMEOUT  default 255  max cycles waiting for dmem_ready per access phase before abort
// PORTS
// - clk         in   1   clock; all state updates on rising edge
// - rst         in   1   asynchronous, active-low reset (0 = reset)
// - start       in   1   request a transaction; accepted only when busy=0
// - mem_op      in   2   00=LD, 01=LDI, 10=ST, 11=STI; latched on accept
// - M_addr      in   16  effective address from execute; latched on accept
// - M_data      in   16  store data (VSR from reg file); latched on accept
// - dmem_addr   out  16  memory address
// - dmem_din    out  16  memory write data
// - dmem_rd     out  1   read request, held until dmem_ready
// - dmem_we     out  1   write request, held until dmem_ready
// - dmem_dout   in   16  memory read data, valid when dmem_ready=1
// - dmem_ready  in   1   memory completes the current request this cycle
// - memout      out  16  last successfully loaded word (to writeback)
// - busy        out  1   high in any state other than IDLE
// - done        out  1   one-cycle pulse when a transaction ends
// - err         out  1   last transaction timed out; cleared on next accept
// BEHAVIOUR
// - Reset: state=IDLE. All outputs 0, including memout, err, dmem_*. Internal pointer and counter are 0.
//   - Asserting reset mid-transaction aborts immediately. No done pulse.
// - FSM states: IDLE, RD_IND, RD_DATA, WR_DATA, DONE. All outputs are registered and decoded from state and latched regs.
// - IDLE: start=1 at an edge latches op, addr and data, and clears err.
//   - LD -> RD_DATA (addr=M_addr)
//   - ST -> WR_DATA (addr=M_addr)
//   - LDI/STI -> RD_IND (addr=M_addr)
// - RD_IND: dmem_rd=1, dmem_addr=latched addr.
//   - On dmem_ready: ptr<=dmem_dout.
//   - LDI -> RD_DATA, STI -> WR_DATA, both using addr=ptr.
// - RD_DATA: dmem_rd=1. On dmem_ready: memout<=dmem_dout, -> DONE.
// - WR_DATA: dmem_we=1, dmem_din=latched data. On dmem_ready -> DONE. memout is unchanged.
// - DONE: done=1 for exactly one cycle, busy=1, -> IDLE.
// - Exclusivity: dmem_rd and dmem_we are never high together. Both are 0 in IDLE and DONE.
// - Handshake rules:
//   - dmem_ready is sampled only in RD_IND, RD_DATA and WR_DATA; it is ignored elsewhere.
//   - Zero-wait memory (ready in the first cycle of the request) is legal.
// - Latency from the accept edge to done high, with zero-wait memory:
//   - LD/ST: 2 cycles
//   - LDI/STI: 3 cycles
//   - Each wait cycle adds 1.
// - start while busy=1 is ignored. It is not queued.
// - start in the same cycle as DONE is also ignored; it must be reissued when busy=0.
// - Watchdog (8-bit counter):
//   - Cleared on entry to every access state. Increments each cycle ready=0.
//   - When count==TIMEOUT with ready=0: err<=1, -> DONE.
//   - On timeout, memout and ptr are unchanged and an STI second phase is skipped.
//   - ready arriving on the same cycle the count hits TIMEOUT wins: normal completion, no err.
// - Address arithmetic: 16-bit, no wrap checks. x0000 and xFFFF are legal addresses.
// TESTING
// - LD, zero-wait: start, op=00, addr=x3000, mem[x3000]=xBEEF.
//   -> rd@x3000 one cycle; done 2 cycles after accept; memout=xBEEF; err=0.
// - LDI, 3-cycle waits: mem[x3001]=x4000, mem[x4000]=x8001.
//   -> rd@x3001, then rd@x4000; memout=x8001; done at accept+9.
// - STI: mem[x3002]=x5000, data=x1234.
//   -> rd@x3002, then we@x5000 din=x1234; mem[x5000]=x1234; memout unchanged.
// - Timeout: TIMEOUT=4, ready held 0 on LD.
//   -> done with err=1 after 5 wait cycles; memout keeps prior value; next accept clears err.
// - Busy/overlap: start pulsed every cycle during an LD.
//   -> only the first is accepted; busy is high throughout; exactly one done.
// - Reset mid-LDI (rst=0 in RD_DATA).
//   -> outputs 0 asynchronously; state IDLE; no done; after release a new ST completes normally.

Source files
------------

// File: rtl/memaccess.sv
// memaccess: LC3 memory-access stage between execute and writeback.
// Runs LD/LDI/ST/STI over a ready-handshaked data-memory port. Indirect ops
// fetch a pointer first. A per-phase watchdog aborts a stalled access and
// flags err. All outputs come straight from flops.
module memaccess #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  mem_op,
    input  logic [15:0] M_addr,
    input  logic [15:0] M_data,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_din,
    output logic        dmem_rd,
    output logic        dmem_we,
    input  logic [15:0] dmem_dout,
    input  logic        dmem_ready,
    output logic [15:0] memout,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // Watchdog compare value; the counter is 8 bits wide.
    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    // mem_op bit 1 selects a store, bit 0 selects an indirect (pointer) access.
    localparam int unsigned OpStoreBit = 1;
    localparam int unsigned OpIndBit   = 0;

    typedef enum logic [2:0] {
        StIdle,
        StRdInd,
        StRdData,
        StWrData,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [15:0] ptr_q, ptr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] memout_q, memout_d;
    logic        err_q, err_d;

    logic [15:0] dmem_addr_q, dmem_addr_d;
    logic [15:0] dmem_din_q, dmem_din_d;
    logic        dmem_rd_q, dmem_rd_d;
    logic        dmem_we_q, dmem_we_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        timed_out;

    // Watchdog fires only when the limit is reached and memory still has not answered.
    assign timed_out = (cnt_q == TimeoutCnt) && !dmem_ready;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            op_q     <= 2'b00;
            addr_q   <= 16'h0000;
            data_q   <= 16'h0000;
            ptr_q    <= 16'h0000;
            cnt_q    <= 8'h00;
            memout_q <= 16'h0000;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            memout_q <= memout_d;
            err_q    <= err_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        data_d   = data_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        memout_d = memout_q;
        err_d    = err_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    op_d   = mem_op;
                    addr_d = M_addr;
                    data_d = M_data;
                    err_d  = 1'b0;
                    cnt_d  = 8'h00;
                    if (mem_op[OpIndBit]) begin
                        state_d = StRdInd;
                    end else if (mem_op[OpStoreBit]) begin
                        state_d = StWrData;
                    end else begin
                        state_d = StRdData;
                    end
                end
            end

            StRdInd: begin
                if (dmem_ready) begin
                    ptr_d   = dmem_dout;
                    cnt_d   = 8'h00;
                    state_d = op_q[OpStoreBit] ? StWrData : StRdData;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            StRdData: begin
                if (dmem_ready) begin
                    memout_d = dmem_dout;
                    state_d  = StDone;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            StWrData: begin
                if (dmem_ready) begin
                    state_d = StDone;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode from the upcoming state so the flopped outputs line up with it.
    always_comb begin
        dmem_addr_d = 16'h0000;
        dmem_din_d  = 16'h0000;
        dmem_rd_d   = 1'b0;
        dmem_we_d   = 1'b0;
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StDone);

        case (state_d)
            StRdInd: begin
                dmem_rd_d   = 1'b1;
                dmem_addr_d = addr_d;
            end
            StRdData: begin
                dmem_rd_d   = 1'b1;
                dmem_addr_d = op_d[OpIndBit] ? ptr_d : addr_d;
            end
            StWrData: begin
                dmem_we_d   = 1'b1;
                dmem_addr_d = op_d[OpIndBit] ? ptr_d : addr_d;
                dmem_din_d  = data_d;
            end
            default: begin
                dmem_rd_d = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dmem_addr_q <= 16'h0000;
            dmem_din_q  <= 16'h0000;
            dmem_rd_q   <= 1'b0;
            dmem_we_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            dmem_addr_q <= dmem_addr_d;
            dmem_din_q  <= dmem_din_d;
            dmem_rd_q   <= dmem_rd_d;
            dmem_we_q   <= dmem_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign dmem_addr = dmem_addr_q;
    assign dmem_din  = dmem_din_q;
    assign dmem_rd   = dmem_rd_q;
    assign dmem_we   = dmem_we_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign memout    = memout_q;
    assign err       = err_q;

endmodule
